alu_muldiv_sequencer: RTL and testbench



---
 rtl/alu_muldiv_sequencer_if.sv | 24 ++
 rtl/alu_muldiv_sequencer.sv | 105 ++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_sequencer_if.sv
// Request/response bundle between the execute-stage core and the multiply/divide sequencer.
// The core drives the request side (master); the sequencer answers on the slave side.
interface alu_muldiv_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  START;
   logic [1:0]            OP;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic                  BUSY;
   logic                  DONE;
   logic [DATA_WIDTH-1:0] RESULT;
   logic                  DIV_ZERO;

   modport master (
      output START, OP, A, B,
      input  BUSY, DONE, RESULT, DIV_ZERO
   );

   modport slave (
      input  START, OP, A, B,
      output BUSY, DONE, RESULT, DIV_ZERO
   );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit: one shift-add or restoring shift-subtract step per clock,
// with a single DATA_WIDTH+1-bit adder shared by both algorithms.
module alu_muldiv_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   alu_muldiv_sequencer_if.slave io_bus
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [1:0]            r_op;
   logic [DATA_WIDTH-1:0] r_opnd;
   logic [DATA_WIDTH-1:0] r_hi;
   logic [DATA_WIDTH-1:0] r_lo;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_divZero;

   logic                  w_isDiv;
   logic [DATA_WIDTH-1:0] w_remShift;
   logic [DATA_WIDTH:0]   w_addX;
   logic [DATA_WIDTH:0]   w_addY;
   logic [DATA_WIDTH:0]   w_sum;
   logic [DATA_WIDTH-1:0] w_hiNext;
   logic [DATA_WIDTH-1:0] w_loNext;
   logic [DATA_WIDTH-1:0] w_runResult;
   logic [DATA_WIDTH-1:0] w_dzResult;
   logic                  w_lastIter;
   logic                  w_startDz;

   // r_hi/r_lo hold P_hi/P_lo for multiply and R/Q for divide; r_opnd is A (multiply) or B (divide).
   // Divide feeds the adder X + ~B + 1, so w_sum[MSB]=1 means the trial subtraction borrowed.
   assign w_isDiv     = r_op[1];
   assign w_remShift  = {r_hi[DATA_WIDTH-2:0], r_lo[DATA_WIDTH-1]};
   assign w_addX      = w_isDiv ? {1'b0, w_remShift} : {1'b0, r_hi};
   assign w_addY      = w_isDiv ? ~{1'b0, r_opnd} : (r_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_sum       = w_addX + w_addY + {{DATA_WIDTH{1'b0}}, w_isDiv};
   assign w_hiNext    = w_isDiv ? (w_sum[DATA_WIDTH] ? w_remShift : w_sum[DATA_WIDTH-1:0])
                                : w_sum[DATA_WIDTH:1];
   assign w_loNext    = w_isDiv ? {r_lo[DATA_WIDTH-2:0], ~w_sum[DATA_WIDTH]}
                                : {w_sum[0], r_lo[DATA_WIDTH-1:1]};
   assign w_runResult = r_op[0] ? w_hiNext : w_loNext;
   assign w_lastIter  = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
   assign w_startDz   = io_bus.OP[1] && (io_bus.B == '0);
   assign w_dzResult  = io_bus.OP[0] ? io_bus.A : '1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // FINISH behaves like IDLE for new requests so back-to-back operations lose no cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, FINISH: begin
            w_nextState = IDLE;
            if (io_bus.START) w_nextState = w_startDz ? FINISH : RUN;
         end
         RUN:     if (w_lastIter) w_nextState = FINISH;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_op      <= '0;
         r_opnd    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_divZero <= 1'b0;
      end else if (r_state == RUN) begin
         r_hi  <= w_hiNext;
         r_lo  <= w_loNext;
         r_cnt <= r_cnt + CNT_WIDTH'(1);
         if (w_lastIter) begin
            r_result  <= w_runResult;
            r_divZero <= 1'b0;
         end
      end else if (io_bus.START) begin
         r_op   <= io_bus.OP;
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= io_bus.OP[1] ? io_bus.A : io_bus.B;
         r_opnd <= io_bus.OP[1] ? io_bus.B : io_bus.A;
         if (w_startDz) begin
            r_result  <= w_dzResult;
            r_divZero <= 1'b1;
         end
      end
   end

   assign io_bus.BUSY     = (r_state == RUN);
   assign io_bus.DONE     = (r_state == FINISH);
   assign io_bus.RESULT   = r_result;
   assign io_bus.DIV_ZERO = r_divZero;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: a cycle-level reference model built from plain 64-bit multiply, / and %
// is compared against the DUT on every falling edge, plus literal checks for the directed operations.
module tb_alu_muldiv_sequencer;

   logic CLK;
   logic RST;
   int   vectors;
   int   miscompares;

   alu_muldiv_sequencer_if #(.DATA_WIDTH(32)) bus ();

   alu_muldiv_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .io_bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      prod = 64'(a) * 64'(b);
      case (op)
         2'd0:    return prod[31:0];
         2'd1:    return prod[63:32];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Reference model: an accepted request completes 32 clocks later; a divide by zero completes at once.
   logic        expBusy, expDone, expDz;
   logic [31:0] expResult, pendRes;
   int          remaining;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         expBusy = 0; expDone = 0; expDz = 0; expResult = 0; remaining = 0;
      end else if (remaining > 0) begin
         remaining--;
         if (remaining == 0) begin
            expBusy = 0; expDone = 1; expResult = pendRes; expDz = 0;
         end
      end else begin
         expDone = 0;
         if (bus.START) begin
            if (bus.OP[1] && bus.B == 0) begin
               expDone = 1; expDz = 1;
               expResult = refResult(bus.OP, bus.A, bus.B);
            end else begin
               expBusy = 1; remaining = 32;
               pendRes = refResult(bus.OP, bus.A, bus.B);
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge CLK) begin
      vectors++;
      if (bus.BUSY !== expBusy || bus.DONE !== expDone || bus.RESULT !== expResult || bus.DIV_ZERO !== expDz) begin
         miscompares++;
         $display("[TB] FAIL cycle t=%0t: busy/done/result/dz got %b/%b/%h/%b expected %b/%b/%h/%b",
                  $time, bus.BUSY, bus.DONE, bus.RESULT, bus.DIV_ZERO, expBusy, expDone, expResult, expDz);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actRes, input logic [31:0] expRes,
                              input logic actDz, input logic expDzIn, input int actLat, input int expLat);
      vectors++;
      if (actRes !== expRes || actDz !== expDzIn || actLat != expLat) begin
         miscompares++;
         $display("[TB] FAIL %s: result=%h dz=%b latency=%0d, expected result=%h dz=%b latency=%0d",
                  name, actRes, actDz, actLat, expRes, expDzIn, expLat);
      end
   endtask

   // Waits (bounded) for DONE; lat counts cycles after the START edge. Optionally scrambles inputs while busy.
   task automatic waitDone(input bit toggle, output int lat);
      lat = 0;
      bus.START = 1'b0;
      while (!bus.DONE && lat < 40) begin
         if (toggle && lat < 28) begin
            bus.A = $urandom; bus.B = $urandom; bus.OP = 2'($urandom); bus.START = 1'($urandom);
         end else begin
            bus.START = 1'b0;
         end
         @(negedge CLK);
         lat++;
      end
      bus.START = 1'b0;
   endtask

   task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expRes, input logic expDzIn, input int expLat, input bit toggle);
      int lat;
      @(negedge CLK);
      bus.START = 1'b1; bus.OP = op; bus.A = a; bus.B = b;
      @(negedge CLK);
      waitDone(toggle, lat);
      checkOutput(name, bus.RESULT, expRes, bus.DIV_ZERO, expDzIn, lat, expLat);
   endtask

   initial begin
      int lat;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      vectors = 0; miscompares = 0;
      RST = 1'b1;
      bus.START = 1'b0; bus.OP = 2'd0; bus.A = '0; bus.B = '0;
      repeat (2) @(negedge CLK);
      checkOutput("reset_state", bus.RESULT, 32'h0, bus.DIV_ZERO, 1'b0, int'(bus.BUSY) + int'(bus.DONE), 0);
      #1 RST = 1'b0;

      applyStimulus("mul_7x6",    2'd0, 32'd7,          32'd6,          32'h0000_002A, 1'b0, 32, 1'b0);
      applyStimulus("mulhu_max",  2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0, 32, 1'b0);
      applyStimulus("mul_max",    2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 32, 1'b0);

      // DIVU then REMU with the second START raised during the first DONE cycle.
      applyStimulus("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd14, 1'b0, 32, 1'b0);
      bus.START = 1'b1; bus.OP = 2'd3; bus.A = 32'd100; bus.B = 32'd7;
      @(negedge CLK);
      waitDone(1'b0, lat);
      checkOutput("remu_b2b", bus.RESULT, 32'd2, bus.DIV_ZERO, 1'b0, lat, 32);

      applyStimulus("mul_toggle", 2'd0, 32'd3, 32'd5, 32'd15, 1'b0, 32, 1'b1);
      applyStimulus("divu_zero",  2'd2, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      applyStimulus("remu_zero",  2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 0, 1'b0);

      // Asynchronous reset in the middle of a divide.
      @(negedge CLK);
      bus.START = 1'b1; bus.OP = 2'd2; bus.A = 32'd1000; bus.B = 32'd3;
      @(negedge CLK);
      bus.START = 1'b0;
      repeat (10) @(negedge CLK);
      #2 RST = 1'b1;
      #1 checkOutput("async_reset", bus.RESULT, 32'h0, bus.DIV_ZERO, 1'b0, int'(bus.BUSY) + int'(bus.DONE), 0);
      @(negedge CLK);
      #1 RST = 1'b0;
      repeat (40) @(negedge CLK);
      checkOutput("no_done_after_reset", bus.RESULT, 32'h0, bus.DIV_ZERO, 1'b0, int'(bus.DONE), 0);

      applyStimulus("mul_2x2", 2'd0, 32'd2, 32'd2, 32'd4, 1'b0, 32, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom);
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 255);
            default: rb = $urandom;
         endcase
         applyStimulus("random", rop, ra, rb, refResult(rop, ra, rb), rop[1] && rb == 0,
                       (rop[1] && rb == 0) ? 0 : 32, i[0]);
      end

      repeat (3) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
